ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port data RAM between two requesters: port 0 (CPU core data bus) and port 1 (debug/DMA loader).
//  Uses a registered req/gnt handshake, bounded burst ownership and 1-cycle read-data return.
//  Sits between the micro top level and the RAM; owns ram_addr / ram_wr_en / ram_data_wr.
// PARAMETERS
//  ADDR_WIDTH   8  RAM address width (tie to RAM_ADDR_WIDTH)
//  DATA_WIDTH   8  RAM data width (tie to RAM_DATA_WIDTH)
//  MAX_BURST    4  max consecutive accesses by one owner while the other port is requesting; must be >= 1
// PORTS
//  clk           in   1           system clock; all state on rising edge
//  arst          in   1           asynchronous reset, active-high
//  req0/req1     in   1           port request; held high while accesses are wanted
//  we0/we1       in   1           1 = write, 0 = read; qualified by req & gnt
//  addr0/addr1   in   ADDR_WIDTH  port address
//  wdata0/wdata1 in   DATA_WIDTH  port write data
//  gnt0/gnt1     out  1           registered grant; an access occurs every cycle with reqN & gntN
//  rvalid0/1     out  1           read data valid, one cycle after the granted read
//  rdata         out  DATA_WIDTH  shared read data (= ram_data_rd), qualify with rvalidN
//  ram_addr      out  ADDR_WIDTH  RAM address
//  ram_wr_en     out  1           RAM write enable
//  ram_data_wr   out  DATA_WIDTH  RAM write data
//  ram_data_rd   in   DATA_WIDTH  RAM read data (synchronous RAM, 1-cycle latency)
// BEHAVIOUR
//  - Reset (async): state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, burst_cnt=0, last_owner=1.
//    Outputs: ram_wr_en=0, ram_addr=0, ram_data_wr=0.
//  - FSM states: IDLE, OWN0, OWN1. gntN = (state==OWNN); grant is a flop output.
//  - IDLE: if no req, stay. If only reqN, go to OWNN. If both, the winner is set by ARB_ROUND_ROBIN_EN.
//    Grant latency from first req in IDLE = 1 cycle.
//  - OWNi: each cycle with req_i=1 is one access. The RAM bus is driven combinationally from port i.
//    ram_wr_en = req_i & we_i.
//  - Leaving OWNi:
//    - req_i=0: go to OWNj if req_j=1, else IDLE. No access occurs in the cycle req_i=0.
//    - burst_cnt==MAX_BURST-1 on an access and req_j=1: go to OWNj. That access still completes (zero-bubble handover).
//  - burst_cnt: +1 per access in OWNi. Cleared on any state change and in IDLE.
//    Saturates at MAX_BURST-1 while req_j=0, so ownership continues indefinitely without competition.
//  - last_owner updates on each entry to OWN0/OWN1.
//  - rvalidN <= access by port N with weN=0 (registered). It follows a read by exactly 1 cycle, including across a handover.
//  - Non-owner port: no RAM side effects, whatever its we/addr/wdata.
//  - In IDLE, or when the owner has req=0: ram_wr_en=0, ram_addr=0, ram_data_wr=0.
//  - A requester must keep reqN, weN, addrN and wdataN stable only in cycles where it holds reqN while gntN=0.
//    The arbiter never drops gntN mid-access.
//  - arst mid-burst: gnt/rvalid drop immediately. Any in-flight read data is discarded. The write in the reset cycle is not guaranteed.
//  - Widths: burst_cnt is $clog2(MAX_BURST)+1 bits. No arithmetic on data or address.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant port != last_owner.
//    First contention after reset grants port 0.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority; port 0 always wins simultaneous requests in IDLE.
//  Burst limit/handover in OWNi is identical in both builds.
// TESTING
//  1. Reset: arst=1 with req0=req1=1 -> gnt0=gnt1=0, ram_wr_en=0, rvalid0/1=0.
//     Release arst -> gnt0=1 on the next edge.
//  2. Single write/read: port0 writes 0xA5 to 0x10, then reads 0x10.
//     Expect ram_wr_en=1 for 1 cycle, then rvalid0=1 with rdata=0xA5 one cycle after the read.
//  3. Contention, MAX_BURST=4: req0 and req1 both held.
//     Expect gnt0 for exactly 4 accesses, then gnt1 for 4, alternating with no idle cycle.
//  4. Simultaneous first request from IDLE: build with ARB_ROUND_ROBIN_EN after a port0-owned burst -> gnt1 first.
//     Build without the macro -> gnt0 first.
//  5. Read at a handover: port0 reads 0x20 on its 4th access while req1 is pending.
//     Expect rvalid0=1 in the same cycle gnt1=1. Expect no rvalid1 unless port1 reads.
//  6. Async reset mid-burst: assert arst in OWN1 -> gnt1=0 and ram_wr_en=0 in the same cycle.
//     After release: IDLE, and a new request is granted after 1 cycle.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter for the single-port data RAM: registered grants, bounded bursts, 1-cycle read return.
// Optional ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests in IDLE (default: port 0 wins).
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_wr_en,
   output logic [DATA_WIDTH-1:0] ram_data_wr,
   input  logic [DATA_WIDTH-1:0] ram_data_rd
);

   localparam int CW = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nx_s;
   logic [CW-1:0]   burst_cnt_r;
   logic            gnt0_r;
   logic            gnt1_r;
   logic            rvalid0_r;
   logic            rvalid1_r;
   logic            acc0_s;
   logic            acc1_s;
   logic            pick1_s;

   assign acc0_s = (state_r == OWN0) & req0;
   assign acc1_s = (state_r == OWN1) & req1;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_owner_r;

   assign pick1_s = ~last_owner_r;

   // Remember which port was most recently granted, updated on entry to an owner state
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         last_owner_r <= 1'b1;
      end else if ((state_nx_s == OWN0) && (state_r != OWN0)) begin
         last_owner_r <= 1'b0;
      end else if ((state_nx_s == OWN1) && (state_r != OWN1)) begin
         last_owner_r <= 1'b1;
      end else begin
         last_owner_r <= last_owner_r;
      end
   end
`else
   assign pick1_s = 1'b0;
`endif

   // Next-state selection; a saturated burst only hands over when the other port is waiting
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (req0 && req1) begin
               state_nx_s = pick1_s ? OWN1 : OWN0;
            end else if (req0) begin
               state_nx_s = OWN0;
            end else if (req1) begin
               state_nx_s = OWN1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         OWN0: begin
            if (!req0) begin
               state_nx_s = req1 ? OWN1 : IDLE;
            end else if ((burst_cnt_r == CNT_MAX) && req1) begin
               state_nx_s = OWN1;
            end else begin
               state_nx_s = OWN0;
            end
         end
         OWN1: begin
            if (!req1) begin
               state_nx_s = req0 ? OWN0 : IDLE;
            end else if ((burst_cnt_r == CNT_MAX) && req0) begin
               state_nx_s = OWN0;
            end else begin
               state_nx_s = OWN1;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // FSM state, grants, burst counter and read-valid flags
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_r     <= IDLE;
         gnt0_r      <= 1'b0;
         gnt1_r      <= 1'b0;
         rvalid0_r   <= 1'b0;
         rvalid1_r   <= 1'b0;
         burst_cnt_r <= '0;
      end else begin
         state_r   <= state_nx_s;
         gnt0_r    <= (state_nx_s == OWN0);
         gnt1_r    <= (state_nx_s == OWN1);
         rvalid0_r <= acc0_s & ~we0;
         rvalid1_r <= acc1_s & ~we1;
         // Staying in an owner state implies an access happened this cycle
         if ((state_nx_s != state_r) || (state_r == IDLE)) begin
            burst_cnt_r <= '0;
         end else if (burst_cnt_r != CNT_MAX) begin
            burst_cnt_r <= burst_cnt_r + CW'(1);
         end else begin
            burst_cnt_r <= burst_cnt_r;
         end
      end
   end

   // RAM bus follows the owning port only while it is actually accessing
   always_comb begin
      ram_addr    = '0;
      ram_wr_en   = 1'b0;
      ram_data_wr = '0;
      if (acc0_s) begin
         ram_addr    = addr0;
         ram_wr_en   = we0;
         ram_data_wr = wdata0;
      end else if (acc1_s) begin
         ram_addr    = addr1;
         ram_wr_en   = we1;
         ram_data_wr = wdata1;
      end else begin
         ram_addr    = '0;
         ram_wr_en   = 1'b0;
         ram_data_wr = '0;
      end
   end

   assign gnt0    = gnt0_r;
   assign gnt1    = gnt1_r;
   assign rvalid0 = rvalid0_r;
   assign rvalid1 = rvalid1_r;
   assign rdata   = ram_data_rd;

endmodule
